wordline_encoder: RTL and testbench

WORDLINE_ENCODER -- requirements
Module: wordline_encoder

---
 rtl/wordline_encoder_if.sv | 24 ++
 rtl/wordline_encoder.sv | 113 +++++++++++
 tb/tb_wordline_encoder.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/wordline_encoder_if.sv
// Handshake and status bundle between a wordline encoder and its producer/consumer.
// The encoder uses the slave modport; the surrounding logic uses the master modport.
`timescale 1ns/1ps

interface wordline_encoder_if;
    logic        load;
    logic [63:0] wordline_in;
    logic        out_ready;
    logic        out_valid;
    logic [5:0]  index_out;
    logic        busy;
    logic        done;
    logic [6:0]  count;

    modport master (
        output load, wordline_in, out_ready,
        input  out_valid, index_out, busy, done, count
    );

    modport slave (
        input  load, wordline_in, out_ready,
        output out_valid, index_out, busy, done, count
    );
endinterface

// File: rtl/wordline_encoder.sv
// Serialises a multi-hot 64-bit wordline into ascending 6-bit indices, one byte group at
// a time, with a valid/ready output handshake and a one-cycle done pulse per load.
`timescale 1ns/1ps

module wordline_encoder (
    input  logic                 clk,
    input  logic                 rst_n,
    wordline_encoder_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [63:0] vec;
    logic [2:0]  group;
    logic [6:0]  count;

    logic [7:0]  cur_byte;
    logic        byte_nz;
    logic [2:0]  lsb_pos;
    logic [5:0]  emit_idx;
    logic        emit_valid;
    logic        accept;

    // Current byte and its lowest set bit; outputs depend on registered state only.
    assign cur_byte   = vec[{group, 3'b000} +: 8];
    assign byte_nz    = |cur_byte;
    assign emit_idx   = {group, lsb_pos};
    assign emit_valid = (state == ST_SCAN) && byte_nz;
    assign accept     = emit_valid && bus.out_ready;

    always_comb begin
        lsb_pos = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (cur_byte[i]) lsb_pos = 3'(i);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the
    // pre-edge values of the others, independent of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // NOTE: every output of this block gets a default before the case statement so no
    // path leaves a value unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state    = state;
        bus.out_valid = 1'b0;
        bus.index_out = 6'h00;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus.load) next_state = ST_SCAN;
            end
            ST_SCAN: begin
                bus.busy = 1'b1;
                if (emit_valid) begin
                    bus.out_valid = 1'b1;
                    bus.index_out = emit_idx;
                end else if (group == 3'd7) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.busy   = 1'b1;
                bus.done   = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Vector, group pointer and accepted-index counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec   <= 64'h0;
            group <= 3'd0;
            count <= 7'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.load) begin
                        vec   <= bus.wordline_in;
                        group <= 3'd0;
                        count <= 7'd0;
                    end
                end
                ST_SCAN: begin
                    if (accept) begin
                        vec[emit_idx] <= 1'b0;
                        count         <= count + 7'd1;
                    end else if (!byte_nz && group != 3'd7) begin
                        // An emptied group still costs its one idle cycle before moving on.
                        group <= group + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.count = count;

endmodule

// File: tb/tb_wordline_encoder.sv
// Directed bench for wordline_encoder: single bits, held handshake, empty and full
// vectors, ignored loads and asynchronous reset mid-scan.
`timescale 1ns/1ps

module tb_wordline_encoder;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    wordline_encoder_if wl_if ();

    wordline_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (wl_if.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_load(input logic [63:0] v);
        wl_if.load        = 1'b1;
        wl_if.wordline_in = v;
        step();
        wl_if.load        = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_steps);
        int n;
        n = 0;
        while (!wl_if.done && n < 200) begin
            step();
            n++;
        end
        check(tag, n, exp_steps);
    endtask

    initial begin
        int exp_idx;
        int done_cnt;
        int done_cyc;

        clk   = 1'b0;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        wl_if.load        = 1'b0;
        wl_if.wordline_in = 64'h0;
        wl_if.out_ready   = 1'b0;

        // Reset state before any clock edge.
        #3;
        check("rst_valid", wl_if.out_valid, 1'b0);
        check("rst_busy",  wl_if.busy,      1'b0);
        check("rst_done",  wl_if.done,      1'b0);
        check("rst_index", wl_if.index_out, 6'h00);
        check("rst_count", wl_if.count,     7'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single bit 0: valid right after the load edge, done nine edges later.
        wl_if.out_ready = 1'b1;
        do_load(64'h0000_0000_0000_0001);
        check("a_valid", wl_if.out_valid, 1'b1);
        check("a_index", wl_if.index_out, 6'd0);
        check("a_busy",  wl_if.busy,      1'b1);
        check("a_count0", wl_if.count,    7'd0);
        wait_done("a_done_lat", 9);
        check("a_count", wl_if.count, 7'd1);
        step();
        check("a_idle_busy",  wl_if.busy,  1'b0);
        check("a_idle_done",  wl_if.done,  1'b0);
        check("a_idle_count", wl_if.count, 7'd1);

        // Single bit 63: seven empty cycles, then index 63, done two cycles after acceptance.
        do_load(64'h8000_0000_0000_0000);
        for (int c = 1; c <= 7; c++) begin
            check("b_empty_valid", wl_if.out_valid, 1'b0);
            check("b_empty_index", wl_if.index_out, 6'h00);
            step();
        end
        check("b_valid", wl_if.out_valid, 1'b1);
        check("b_index", wl_if.index_out, 6'd63);
        step();
        check("b_after_valid", wl_if.out_valid, 1'b0);
        check("b_after_done",  wl_if.done,      1'b0);
        check("b_count",       wl_if.count,     7'd1);
        step();
        check("b_done", wl_if.done, 1'b1);
        step();

        // Bits 8 and 9 with the consumer stalled for three cycles.
        wl_if.out_ready = 1'b0;
        do_load(64'h0000_0000_0000_0300);
        check("c_g0_valid", wl_if.out_valid, 1'b0);
        step();
        for (int c = 0; c < 3; c++) begin
            check("c_hold_valid", wl_if.out_valid, 1'b1);
            check("c_hold_index", wl_if.index_out, 6'd8);
            check("c_hold_count", wl_if.count,     7'd0);
            if (c < 2) step();
        end
        wl_if.out_ready = 1'b1;
        step();
        check("c_second_index", wl_if.index_out, 6'd9);
        check("c_second_valid", wl_if.out_valid, 1'b1);
        check("c_mid_count",    wl_if.count,     7'd1);
        step();
        check("c_end_valid", wl_if.out_valid, 1'b0);
        check("c_end_count", wl_if.count,     7'd2);
        wait_done("c_done_lat", 7);
        step();

        // All-zero vector: nine busy cycles, no output; a load during SCAN is ignored.
        do_load(64'h0);
        check("d_count_cleared", wl_if.count, 7'd0);
        for (int c = 1; c <= 9; c++) begin
            check("d_busy",  wl_if.busy,      1'b1);
            check("d_valid", wl_if.out_valid, 1'b0);
            check("d_done",  wl_if.done,      (c == 9));
            if (c == 3) begin
                wl_if.load        = 1'b1;
                wl_if.wordline_in = 64'hFFFF_FFFF_FFFF_FFFF;
            end else if (c == 4) begin
                wl_if.load = 1'b0;
            end
            step();
        end
        check("d_idle_busy",  wl_if.busy,      1'b0);
        check("d_idle_valid", wl_if.out_valid, 1'b0);
        check("d_count",      wl_if.count,     7'd0);

        // All-ones vector: 0..63 ascending, count reaches 64, single done pulse.
        exp_idx  = 0;
        done_cnt = 0;
        done_cyc = 0;
        do_load(64'hFFFF_FFFF_FFFF_FFFF);
        for (int c = 1; c <= 80; c++) begin
            if (wl_if.out_valid) begin
                check("e_index", wl_if.index_out, exp_idx);
                exp_idx++;
            end
            if (wl_if.done) begin
                done_cnt++;
                done_cyc = c;
            end
            step();
        end
        check("e_emitted",  exp_idx,     64);
        check("e_done_cnt", done_cnt,    1);
        check("e_done_cyc", done_cyc,    73);
        check("e_count",    wl_if.count, 7'd64);
        check("e_idle",     wl_if.busy,  1'b0);

        // Asynchronous reset mid-scan, then a fresh load on the first edge after release.
        do_load(64'h0000_0000_0000_00F0);
        check("f_first_index", wl_if.index_out, 6'd4);
        step();
        check("f_second_index", wl_if.index_out, 6'd5);
        check("f_count_pre",    wl_if.count,     7'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("f_rst_valid", wl_if.out_valid, 1'b0);
        check("f_rst_busy",  wl_if.busy,      1'b0);
        check("f_rst_index", wl_if.index_out, 6'h00);
        check("f_rst_count", wl_if.count,     7'd0);
        check("f_rst_done",  wl_if.done,      1'b0);
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            check("f_hold_done", wl_if.done, 1'b0);
            step();
        end
        rst_n = 1'b1;
        do_load(64'h0000_0400_0000_0000);
        check("f_reload_busy", wl_if.busy, 1'b1);
        for (int c = 1; c <= 5; c++) begin
            check("f_reload_empty", wl_if.out_valid, 1'b0);
            check("f_reload_done",  wl_if.done,      1'b0);
            step();
        end
        check("f_reload_valid", wl_if.out_valid, 1'b1);
        check("f_reload_index", wl_if.index_out, 6'd42);
        step();
        check("f_reload_count", wl_if.count, 7'd1);
        wait_done("f_done_lat", 3);
        step();
        check("f_final_busy", wl_if.busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
